coord_int_queue: RTL and testbench
==================================

# coord_int_queue

Parametrised successor to the single-entry `grid_coord` register. Buffers up to DEPTH board coordinates from the input processing unit and range-checks each one. Raises `ipu_int` to the processor while a coordinate is pending. Retires one entry per `int_ack` handshake, so rapid player input is never lost or overwritten while the processor services an earlier move.

## Interface
Parameters:
- COORD_W, 4, width of one grid coordinate
- DEPTH, 4, queue entries; power of two, ≥2
- MAX_COORD, 8, highest legal coordinate (3x3 board = 0..8); larger values rejected

Ports:
- clk  in  1  single system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0), synchronous release
- write_en  in  1  IPU strobe, one coordinate per high cycle
- coord_in  in  COORD_W  coordinate sampled when write_en=1
- int_ack  in  1  processor acknowledge level
- clr_ovf  in  1  clears sticky `overflow`
- ipu_int  out  1  interrupt request to processor
- coord_out  out  COORD_W  head entry; stable while ipu_int=1
- count  out  $clog2(DEPTH+1)  entries held
- full  out  1  count==DEPTH
- empty  out  1  count==0
- overflow  out  1  sticky: a legal write was dropped because the queue was full
- bad_coord  out  1  one-cycle pulse: write rejected, coord_in > MAX_COORD

## Operation
- Reset: queue empty, count=0, empty=1, full=0, ipu_int=0, coord_out=0, overflow=0, bad_coord=0, FSM=IDLE.
- Write, when write_en=1:
  - coord_in > MAX_COORD: drop it, pulse bad_coord next cycle, leave count unchanged.
  - Otherwise push, unless full with no pop in the same cycle. In that case drop it and set overflow.
- Interrupt FSM:
  - IDLE: ipu_int=0. Go to PEND when empty=0.
  - PEND: ipu_int=1 and coord_out=head. On int_ack=1, pop the head and go to ACK.
  - ACK: ipu_int=0. Wait for int_ack=0, then return to IDLE.
- One pop per handshake. A held int_ack never pops twice.
- Pop is only possible from PEND, so an empty pop cannot occur.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - A write to a full queue in a pop cycle is accepted.
  - A write to an empty queue while in ACK is held until IDLE.
- overflow clears only on clr_ovf=1. If clr_ovf and a new overflow event coincide, overflow stays set.
- coord_out holds the last head value when empty.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately.

## Timing
- Write in cycle N into an empty queue with FSM in IDLE: empty=0 and count=1 after edge N; ipu_int=1 after edge N+1.
- int_ack rises at edge M: ipu_int=0 and count decrements after edge M.
- int_ack falls: FSM is in IDLE after the next edge. If entries remain, ipu_int reasserts one edge later. Minimum 2-cycle gap between interrupts.
- bad_coord is a registered pulse, high exactly one cycle after the offending write.
- rst asserted mid-operation: all outputs return to reset values immediately and queue contents are discarded. A pending int_ack is ignored until the FSM reaches PEND again.

## Structure
- Shared `gcttt_pkg`:
  - COORD_W and MAX_COORD defaults
  - FSM state typedef (IDLE, PEND, ACK)
- Sub-module `coord_fifo`: synchronous circular buffer with push/pop, count, full and empty, parametrised on COORD_W and DEPTH.
- The top level holds range check, overflow logic and the interrupt FSM.

## Test plan
- Reset then a single write of 4'd2 → ipu_int=1 two edges later, coord_out=2. Ack pulse → ipu_int=0, count=0, empty=1.
- Back-to-back writes 1,5,7 while int_ack=0 → count=3. Three ack handshakes present coord_out=1, then 5, then 7 in order. Ack held high 5 cycles pops only once.
- DEPTH=4: five writes 0,1,2,3,4 with no ack → full=1, overflow=1, queue holds 0..3. clr_ovf → overflow=0.
- Write 4'd9 and 4'd15 → bad_coord pulses twice, count stays 0, ipu_int stays 0.
- Full queue: write 6 in the same cycle int_ack rises in PEND → count stays 4, 6 becomes tail, overflow=0.
- rst low mid-service with count=2 in ACK → ipu_int=0, count=0, overflow=0 immediately. After release the next write behaves as the first scenario.

Source files
------------

// File: rtl/gcttt_pkg.sv
// gcttt_pkg: shared definitions for the grid-coordinate interrupt queue.
//   COORD_W_DEF   - default width of one board coordinate
//   MAX_COORD_DEF - default highest legal coordinate (3x3 board: 0..8)
//   int_state_e   - interrupt handshake FSM states
package gcttt_pkg;

    localparam int COORD_W_DEF   = 4;
    localparam int MAX_COORD_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } int_state_e;

endpackage

// File: rtl/coord_fifo.sv
// coord_fifo: synchronous circular buffer of board coordinates.
//   clk, rst   - clock, async active-low reset
//   push/wdata - enqueue wdata (ignored when full unless pop is also high)
//   pop        - dequeue head (ignored when empty)
//   rdata      - current head entry (meaningful only when !empty)
//   count      - entries held; full/empty derived from it
module coord_fifo #(
    parameter int COORD_W = 4,
    parameter int DEPTH   = 4,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [COORD_W-1:0] wdata,
    output logic [COORD_W-1:0] rdata,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty
);
    import gcttt_pkg::*;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DEPTH-1:0][COORD_W-1:0] mem_q, mem_d;
    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                 count_q, count_d;
    logic                          do_push, do_pop;

    assign count = count_q;
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // A pop frees a slot in the same cycle, so a full queue may still accept.
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/coord_int_queue.sv
// coord_int_queue: buffers range-checked board coordinates from the IPU and
// interrupts the processor once per queued entry.
//   clk, rst          - clock, async active-low reset
//   write_en/coord_in - IPU write strobe and coordinate
//   int_ack, ipu_int  - processor acknowledge level / interrupt request
//   clr_ovf           - clears sticky overflow
//   coord_out         - head entry (last head when empty)
//   count/full/empty  - queue occupancy
//   overflow          - sticky: legal write dropped on a full queue
//   bad_coord         - one-cycle pulse after an out-of-range write
module coord_int_queue
    import gcttt_pkg::*;
#(
    parameter int COORD_W   = COORD_W_DEF,
    parameter int DEPTH     = 4,
    parameter int MAX_COORD = MAX_COORD_DEF,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write_en,
    input  logic [COORD_W-1:0] coord_in,
    input  logic               int_ack,
    input  logic               clr_ovf,
    output logic               ipu_int,
    output logic [COORD_W-1:0] coord_out,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic               bad_coord
);

    localparam logic [COORD_W-1:0] MAX_C = COORD_W'(MAX_COORD);

    int_state_e         state_q, state_d;
    logic               overflow_q, overflow_d;
    logic               bad_coord_q, bad_coord_d;
    logic [COORD_W-1:0] last_q, last_d;
    logic [COORD_W-1:0] head;
    logic               legal_wr, push, pop;

    assign legal_wr = write_en && (coord_in <= MAX_C);
    // Pop happens only on the acknowledge edge out of PEND, so a held
    // int_ack retires exactly one entry and an empty pop is impossible.
    assign pop      = (state_q == PEND) && int_ack;
    assign push     = legal_wr && (!full || pop);

    coord_fifo #(
        .COORD_W (COORD_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (coord_in),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty)  state_d = PEND;
            PEND:    if (int_ack) state_d = ACK;
            ACK:     if (!int_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        overflow_d  = clr_ovf ? 1'b0 : overflow_q;
        // A new drop wins over a simultaneous clear.
        if (legal_wr && full && !pop) overflow_d = 1'b1;
        bad_coord_d = write_en && (coord_in > MAX_C);
        // Remember the head so coord_out keeps it once the queue drains.
        last_d      = empty ? last_q : head;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            overflow_q  <= 1'b0;
            bad_coord_q <= 1'b0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            bad_coord_q <= bad_coord_d;
            last_q      <= last_d;
        end
    end

    assign ipu_int   = (state_q == PEND);
    assign coord_out = empty ? last_q : head;
    assign overflow  = overflow_q;
    assign bad_coord = bad_coord_q;

endmodule

// File: tb/tb_coord_int_queue.sv
module tb_coord_int_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       write_en = 1'b0;
    logic [3:0] coord_in = '0;
    logic       int_ack = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       ipu_int;
    logic [3:0] coord_out;
    logic [2:0] count;
    logic       full, empty, overflow, bad_coord;

    int         checks = 0;
    int         failures = 0;
    int         model_cnt = 0;
    logic [3:0] sb[$];

    coord_int_queue #(.COORD_W(4), .DEPTH(4), .MAX_COORD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .write_en  (write_en),
        .coord_in  (coord_in),
        .int_ack   (int_ack),
        .clr_ovf   (clr_ovf),
        .ipu_int   (ipu_int),
        .coord_out (coord_out),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .bad_coord (bad_coord)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle write; the bench model decides whether it is queued.
    task automatic do_write(input logic [3:0] c);
        write_en = 1'b1;
        coord_in = c;
        tick();
        write_en = 1'b0;
        if (c <= 4'd8 && model_cnt < 4) begin
            sb.push_back(c);
            model_cnt++;
        end
    endtask

    // Full ack handshake; int_ack held for 1+hold edges.
    task automatic handshake(input int hold);
        int         waited;
        logic [3:0] exp;
        waited = 0;
        while (ipu_int !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        checks++;
        if (ipu_int !== 1'b1) begin
            failures++;
            $display("FAIL hs_int_timeout got=%b exp=1", ipu_int);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 4'hx;
        checks++;
        if (coord_out !== exp) begin
            failures++;
            $display("FAIL hs_coord_out got=%0d exp=%0d", coord_out, exp);
        end
        int_ack = 1'b1;
        tick();
        model_cnt--;
        checks++;
        if (ipu_int !== 1'b0 || count !== 3'(model_cnt)) begin
            failures++;
            $display("FAIL hs_ack_edge got int=%b cnt=%0d exp int=0 cnt=%0d", ipu_int, count, model_cnt);
        end
        repeat (hold) tick();
        checks++;
        if (ipu_int !== 1'b0 || count !== 3'(model_cnt)) begin
            failures++;
            $display("FAIL hs_ack_held got int=%b cnt=%0d exp int=0 cnt=%0d", ipu_int, count, model_cnt);
        end
        int_ack = 1'b0;
        tick();
        checks++;
        if (ipu_int !== 1'b0) begin
            failures++;
            $display("FAIL hs_idle_gap got=%b exp=0", ipu_int);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({ipu_int, coord_out, count, full, empty, overflow, bad_coord} !== {1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got int=%b out=%0d cnt=%0d full=%b empty=%b ovf=%b bad=%b exp 0,0,0,0,1,0,0",
                     ipu_int, coord_out, count, full, empty, overflow, bad_coord);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_write(4'd2);
        checks++;
        if (count !== 3'd1 || empty !== 1'b0 || ipu_int !== 1'b0) begin
            failures++;
            $display("FAIL single_edge_n got cnt=%0d empty=%b int=%b exp 1,0,0", count, empty, ipu_int);
        end
        tick();
        checks++;
        if (ipu_int !== 1'b1 || coord_out !== 4'd2) begin
            failures++;
            $display("FAIL single_int got int=%b out=%0d exp 1,2", ipu_int, coord_out);
        end
        handshake(0);
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || coord_out !== 4'd2) begin
            failures++;
            $display("FAIL single_drained got cnt=%0d empty=%b out=%0d exp 0,1,2", count, empty, coord_out);
        end
    endtask

    task automatic test_back_to_back();
        do_write(4'd1);
        do_write(4'd5);
        do_write(4'd7);
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", count);
        end
        handshake(4);
        handshake(0);
        handshake(0);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL b2b_empty got=%b exp=1", empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) do_write(4'(i));
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pre got full=%b ovf=%b exp 1,0", full, overflow);
        end
        do_write(4'd4);
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || count !== 3'd4) begin
            failures++;
            $display("FAIL ovf_set got full=%b ovf=%b cnt=%0d exp 1,1,4", full, overflow, count);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b exp=0", overflow);
        end
    endtask

    // Queue is full (0..3) and PEND: push 6 on the same edge the ack pops.
    task automatic test_full_push_pop();
        logic [3:0] exp;
        checks++;
        if (ipu_int !== 1'b1) begin
            failures++;
            $display("FAIL fpp_pend got=%b exp=1", ipu_int);
        end
        exp = sb.pop_front();
        checks++;
        if (coord_out !== exp) begin
            failures++;
            $display("FAIL fpp_head got=%0d exp=%0d", coord_out, exp);
        end
        write_en = 1'b1;
        coord_in = 4'd6;
        int_ack  = 1'b1;
        tick();
        write_en = 1'b0;
        sb.push_back(4'd6);
        checks++;
        if (count !== 3'd4 || overflow !== 1'b0 || ipu_int !== 1'b0) begin
            failures++;
            $display("FAIL fpp_edge got cnt=%0d ovf=%b int=%b exp 4,0,0", count, overflow, ipu_int);
        end
        int_ack = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) handshake(0);
        checks++;
        if (empty !== 1'b1 || coord_out !== 4'd6) begin
            failures++;
            $display("FAIL fpp_drain got empty=%b out=%0d exp 1,6", empty, coord_out);
        end
    endtask

    task automatic test_bad_coord();
        do_write(4'd9);
        checks++;
        if (bad_coord !== 1'b1) begin
            failures++;
            $display("FAIL bad9_pulse got=%b exp=1", bad_coord);
        end
        tick();
        checks++;
        if (bad_coord !== 1'b0) begin
            failures++;
            $display("FAIL bad9_end got=%b exp=0", bad_coord);
        end
        do_write(4'd15);
        checks++;
        if (bad_coord !== 1'b1) begin
            failures++;
            $display("FAIL bad15_pulse got=%b exp=1", bad_coord);
        end
        tick();
        checks++;
        if (bad_coord !== 1'b0 || count !== 3'd0 || ipu_int !== 1'b0) begin
            failures++;
            $display("FAIL bad_after got bad=%b cnt=%0d int=%b exp 0,0,0", bad_coord, count, ipu_int);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        for (int i = 1; i <= 5; i++) do_write(4'(i));
        handshake(0);
        waited = 0;
        while (ipu_int !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        int_ack = 1'b1;
        tick();
        model_cnt--;
        void'(sb.pop_front());
        checks++;
        if (count !== 3'd2 || overflow !== 1'b1 || ipu_int !== 1'b0) begin
            failures++;
            $display("FAIL rmid_pre got cnt=%0d ovf=%b int=%b exp 2,1,0", count, overflow, ipu_int);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ipu_int, count, overflow, empty, coord_out} !== {1'b0, 3'd0, 1'b0, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL rmid_async got int=%b cnt=%0d ovf=%b empty=%b out=%0d exp 0,0,0,1,0",
                     ipu_int, count, overflow, empty, coord_out);
        end
        sb.delete();
        model_cnt = 0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (ipu_int !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL rmid_ack_ignored got int=%b cnt=%0d exp 0,0", ipu_int, count);
        end
        int_ack = 1'b0;
        tick();
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_bad_coord();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
